// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe
// Brief    : ID/EX pipeline register with valid/ready handshake, synchronous
//            flush to a NOP bubble and optional two-entry skid buffer
//            (enabled by defining ID_EX_SKID_EN).
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe #(
    parameter int              XLEN     = 32,
    parameter int              REG_AW   = 5,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [XLEN-1:0]   inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_wen_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_wen_o
);

    localparam int c_pw = 4*XLEN + REG_AW + 1;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_full  = 2'd1;
`ifdef ID_EX_SKID_EN
    localparam logic [1:0] c_st_skid  = 2'd2;
`endif

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_valid;
    logic [c_pw-1:0] r_main;
    logic [c_pw-1:0] w_main_nxt;
    logic [c_pw-1:0] w_in_pl;
    logic [c_pw-1:0] w_bubble;
    logic            w_in;
    logic            w_out;

    assign w_in_pl  = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};
    assign w_bubble = {NOP_INST, {(3*XLEN + REG_AW + 1){1'b0}}};

    assign w_in  = valid_i & ready_o;
    assign w_out = r_valid & ready_i;

    assign valid_o = r_valid;
    assign {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o} = r_main;

`ifdef ID_EX_SKID_EN
    logic            r_ready;
    logic [c_pw-1:0] r_skid;
    logic [c_pw-1:0] w_skid_nxt;

    // Registered ready: no combinational path from ready_i to ready_o.
    assign ready_o = r_ready;
`else
    assign ready_o = ready_i | ~r_valid;
`endif

    // Main always holds the older beat; the skid entry only ever holds the
    // younger one, so draining is a simple skid -> main move.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
`ifdef ID_EX_SKID_EN
        w_skid_nxt  = r_skid;
`endif
        if (flush_i) begin
            w_state_nxt = c_st_empty;
            w_main_nxt  = w_bubble;
`ifdef ID_EX_SKID_EN
            w_skid_nxt  = w_bubble;
`endif
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_in) begin
                        w_state_nxt = c_st_full;
                        w_main_nxt  = w_in_pl;
                    end
                end
                c_st_full: begin
                    if (w_in && w_out) begin
                        w_main_nxt = w_in_pl;
                    end else if (w_out) begin
                        w_state_nxt = c_st_empty;
                        w_main_nxt  = w_bubble;
`ifdef ID_EX_SKID_EN
                    end else if (w_in) begin
                        w_state_nxt = c_st_skid;
                        w_skid_nxt  = w_in_pl;
`endif
                    end
                end
`ifdef ID_EX_SKID_EN
                c_st_skid: begin
                    if (w_out) begin
                        w_state_nxt = c_st_full;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = w_bubble;
                    end
                end
`endif
                default: begin
                    w_state_nxt = c_st_empty;
                    w_main_nxt  = w_bubble;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_empty;
            r_valid <= 1'b0;
            r_main  <= w_bubble;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != c_st_empty);
            r_main  <= w_main_nxt;
        end
    end

`ifdef ID_EX_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_skid  <= w_bubble;
        end else begin
            r_ready <= (w_state_nxt != c_st_skid);
            r_skid  <= w_skid_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe
// Brief    : Self-checking bench for id_ex_pipe: queue-based reference model,
//            per-cycle output comparison and directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe;

    localparam int              XLEN     = 32;
    localparam int              REG_AW   = 5;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;
`ifdef ID_EX_SKID_EN
    localparam int              CAPACITY = 2;
`else
    localparam int              CAPACITY = 1;
`endif

    typedef struct packed {
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [REG_AW-1:0] rd;
        logic              wen;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [XLEN-1:0]   inst_i = '0;
    logic [XLEN-1:0]   inst_addr_i = '0;
    logic [XLEN-1:0]   op1_i = '0;
    logic [XLEN-1:0]   op2_i = '0;
    logic [REG_AW-1:0] rd_addr_i = '0;
    logic              reg_wen_i = 1'b0;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [XLEN-1:0]   inst_o;
    logic [XLEN-1:0]   inst_addr_o;
    logic [XLEN-1:0]   op1_o;
    logic [XLEN-1:0]   op2_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              reg_wen_o;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    beat_t q[$];

    id_ex_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: a FIFO of at most CAPACITY beats.
    function automatic bit model_ready();
        if (CAPACITY == 2) return (q.size() < 2);
        return ready_i || (q.size() == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            automatic bit    acc  = valid_i && model_ready();
            automatic bit    take = (q.size() > 0) && ready_i;
            automatic beat_t b    = '{inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};
            if (flush_i) begin
                q.delete();
            end else begin
                if (take) void'(q.pop_front());
                if (acc)  q.push_back(b);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic beat_t e = '{NOP, '0, '0, '0, '0, 1'b0};
            if (q.size() > 0) e = q[0];
            chk("valid_o",     {63'd0, valid_o},      {63'd0, (q.size() > 0)});
            chk("ready_o",     {63'd0, ready_o},      {63'd0, model_ready()});
            chk("inst_o",      {32'd0, inst_o},       {32'd0, e.inst});
            chk("inst_addr_o", {32'd0, inst_addr_o},  {32'd0, e.addr});
            chk("op1_o",       {32'd0, op1_o},        {32'd0, e.op1});
            chk("op2_o",       {32'd0, op2_o},        {32'd0, e.op2});
            chk("rd_addr_o",   {59'd0, rd_addr_o},    {59'd0, e.rd});
            chk("reg_wen_o",   {63'd0, reg_wen_o},    {63'd0, e.wen});
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic step(input bit v, input logic [XLEN-1:0] pc, input bit rdy, input bit fl);
        valid_i     = v;
        inst_addr_i = pc;
        inst_i      = $urandom;
        op1_i       = $urandom;
        op2_i       = $urandom;
        rd_addr_i   = REG_AW'($urandom);
        reg_wen_i   = 1'($urandom);
        ready_i     = rdy;
        flush_i     = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"},  {63'd0, valid_o},     64'd0);
        chk({tag, ".inst"},   {32'd0, inst_o},      64'h13);
        chk({tag, ".addr"},   {32'd0, inst_addr_o}, 64'd0);
        chk({tag, ".wen"},    {63'd0, reg_wen_o},   64'd0);
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'($urandom); ready_i = 1'($urandom); flush_i = 1'($urandom);
            inst_i = $urandom; inst_addr_i = $urandom; op1_i = $urandom;
            op2_i = $urandom; rd_addr_i = REG_AW'($urandom); reg_wen_i = 1'($urandom);
            @(posedge clk);
            #2;
        end
        chk_bubble("reset");
        chk("reset.op1",   {32'd0, op1_o},     64'd0);
        chk("reset.op2",   {32'd0, op2_o},     64'd0);
        chk("reset.rd",    {59'd0, rd_addr_o}, 64'd0);
        ready_i = 1'b0;
        chk("reset.ready", {63'd0, ready_o},   64'd1);
        valid_i = 1'b0; flush_i = 1'b0;
        rst_n   = 1'b1;
        cmp_en  = 1'b1;
        @(posedge clk);
        #2;

        // Streaming
        step(1, 32'h0, 1, 0);
        chk("stream.pc0", {32'd0, inst_addr_o}, 64'h0);
        chk("stream.v0",  {63'd0, valid_o},     64'd1);
        step(1, 32'h4, 1, 0);
        chk("stream.pc4", {32'd0, inst_addr_o}, 64'h4);
        chk("stream.v4",  {63'd0, valid_o},     64'd1);
        step(1, 32'h8, 1, 0);
        chk("stream.pc8", {32'd0, inst_addr_o}, 64'h8);
        chk("stream.v8",  {63'd0, valid_o},     64'd1);
        step(0, 32'h0, 1, 0);
        chk("stream.drain", {63'd0, valid_o}, 64'd0);

        // Backpressure
        step(1, 32'h10, 0, 0);
        chk("bp.first", {32'd0, inst_addr_o}, 64'h10);
`ifdef ID_EX_SKID_EN
        step(1, 32'h14, 0, 0);
        chk("bp.ready_low", {63'd0, ready_o},     64'd0);
        chk("bp.hold",      {32'd0, inst_addr_o}, 64'h10);
        step(0, 32'h0, 1, 0);
        chk("bp.second",    {32'd0, inst_addr_o}, 64'h14);
        chk("bp.ready_up",  {63'd0, ready_o},     64'd1);
`else
        chk("bp.ready_low", {63'd0, ready_o}, 64'd0);
        step(1, 32'h14, 0, 0);
        chk("bp.hold",      {32'd0, inst_addr_o}, 64'h10);
`endif
        step(0, 32'h0, 1, 0);
        chk("bp.empty", {63'd0, valid_o}, 64'd0);

        // Flush with both entries occupied
        step(1, 32'h20, 0, 0);
`ifdef ID_EX_SKID_EN
        step(1, 32'h24, 0, 0);
`endif
        step(0, 32'h0, 0, 1);
        chk_bubble("flush_full");
        chk("flush_full.ready", {63'd0, ready_o}, 64'd1);
        step(0, 32'h0, 1, 0);
        chk("flush_full.no24", {63'd0, valid_o}, 64'd0);

        // Flush coinciding with an accepted beat
        step(1, 32'h30, 1, 1);
        chk_bubble("flush_in");
        step(0, 32'h0, 1, 0);
        chk("flush_in.empty", {63'd0, valid_o}, 64'd0);

        // Asynchronous reset between edges
        step(1, 32'h40, 0, 0);
        chk("areset.full", {63'd0, valid_o}, 64'd1);
        valid_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_bubble("areset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) != 0), $urandom, 1'($urandom),
                 ($urandom_range(15) == 0));
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
